counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
Sequencing controller for a programmable up-counter, built on the same saturating and wrapping counter datapath used in the counter blocks. A small FSM accepts start, stop and pause commands and latches a terminal value and mode at start. It then runs the counter either one-shot (count up, hold at the limit) or periodic (count 0..limit, then wrap). It reports busy, done and wrap events plus a wrap tally for the surrounding logic.

Parameters:
WIDTH, 7, counter and limit width in bits
DEFAULT_LIMIT, 100, reset value of the latched limit; must fit in WIDTH bits
WRAPW, 8, width of the wrap tally

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
i_start  input  1  start command; level sampled each edge
i_stop  input  1  abort command; highest priority
i_pause  input  1  hold count while high (RUN/PAUSE only)
i_mode  input  1  0 = one-shot, 1 = periodic; latched on accepted start
i_limit  input  WIDTH  terminal value; latched on accepted start
o_cnt  output  WIDTH  current count
o_state  output  2  FSM state encoding
o_busy  output  1  high in RUN or PAUSE
o_done  output  1  one-cycle pulse on entry to DONE
o_wrap  output  1  one-cycle pulse on each periodic wrap
o_wrap_cnt  output  WRAPW  wraps since last start, saturating

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low; assertion takes effect immediately, independent of clk.
- Reset values: state IDLE, o_cnt 0, lim_q DEFAULT_LIMIT, mode_q 0, o_done 0, o_wrap 0, o_wrap_cnt 0, o_busy 0.
- Reset mid-operation forces these values immediately; there is no resume after reset.
- All outputs are registered or decoded directly from state. There are no combinational paths from inputs to outputs.
- State encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Command priority, every state: i_stop > i_start > i_pause.
- IDLE: o_cnt held at 0.
  - i_start && !i_stop: latch lim_q<=i_limit and mode_q<=i_mode; o_cnt<=0; o_wrap_cnt<=0; go to RUN.
- RUN:
  - i_stop: go to IDLE, o_cnt<=0.
  - Else i_pause: go to PAUSE, o_cnt held.
  - Else if o_cnt==lim_q and mode_q==0: go to DONE, o_cnt held at lim_q, o_done<=1.
  - Else if o_cnt==lim_q and mode_q==1: o_cnt<=0, o_wrap<=1, o_wrap_cnt<=o_wrap_cnt+1 (holds at all-ones); stay in RUN.
  - Else: o_cnt<=o_cnt+1.
  - i_start is ignored in RUN.
- PAUSE: o_cnt held.
  - i_stop: go to IDLE, o_cnt<=0.
  - Else !i_pause: go to RUN; counting resumes on the following edge.
  - i_start is ignored in PAUSE.
- DONE: o_cnt held at lim_q.
  - i_stop: go to IDLE, o_cnt<=0.
  - Else i_start: restart exactly as from IDLE, with a new latch.
- Pulses: o_done and o_wrap are high for exactly one cycle and are otherwise cleared every edge.
- Latency: with start accepted at edge E0, o_cnt=n after edge En.
  - One-shot: o_done is high after edge E(lim+1).
  - Periodic: period is lim+1 cycles.
- Arithmetic: o_cnt never exceeds lim_q, so the WIDTH-bit increment cannot overflow.
  - lim_q=2^WIDTH-1 is legal.
- lim_q=0:
  - One-shot reaches DONE after one RUN cycle.
  - Periodic asserts o_wrap every RUN cycle, with o_cnt fixed at 0.
- i_limit and i_mode changes while busy have no effect until the next accepted start.
- Simultaneous i_start and i_stop in IDLE or DONE: stop wins, and the result is IDLE with o_cnt 0.

Test Plan:
- Reset: assert reset_n=0 mid-RUN at o_cnt=37 -> o_cnt=0, state=0, o_busy=0 immediately without a clock edge; release, no activity until i_start.
- One-shot, limit 100: pulse i_start with i_mode=0, i_limit=100 -> o_cnt goes 0..100 and holds at 100; o_done high for exactly one cycle after edge E101; state=3; o_busy=0.
- Periodic, limit 99: i_mode=1, i_limit=99, run 250 cycles -> sequence 0..99,0..99,0..49; o_wrap pulses after E100 and E200; o_wrap_cnt=2.
- Pause/resume: pause at o_cnt=20 for 5 cycles -> o_cnt stays 20 with o_busy=1; after release o_cnt=21 one edge after RUN re-entry; done timing shifts by 6 cycles.
- Priorities: i_start+i_stop in IDLE -> stay IDLE. i_stop+i_pause in RUN at o_cnt=5 -> IDLE, o_cnt=0. i_start while RUN -> ignored, lim_q unchanged.
- Edge limits: i_limit=0 one-shot -> o_done after E1. i_limit=127 periodic, 300 wraps with WRAPW=8 -> o_wrap_cnt saturates at 255; restart clears it to 0.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a programmable up-counter.
// Runs the counter one-shot (hold at limit) or periodic (wrap at limit) under start/stop/pause commands.
module counter_seq_ctrl #(
    parameter int WIDTH         = 7,
    parameter int DEFAULT_LIMIT = 100,
    parameter int WRAPW         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_pause,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_cnt,
    output logic [1:0]       o_state,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_wrap,
    output logic [WRAPW-1:0] o_wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] LIMIT_RST = WIDTH'(DEFAULT_LIMIT);
    localparam logic [WRAPW-1:0] WRAP_MAX  = '1;

    state_t           state;
    logic [WIDTH-1:0] lim_q;
    logic             mode_q;

    assign o_state = state;
    assign o_busy  = (state == RUN) || (state == PAUSE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            o_cnt      <= '0;
            lim_q      <= LIMIT_RST;
            mode_q     <= 1'b0;
            o_done     <= 1'b0;
            o_wrap     <= 1'b0;
            o_wrap_cnt <= '0;
        end else begin
            // NOTE: pulses default low every edge; a later non-blocking write in this block wins, so the branches below only need to raise them.
            o_done <= 1'b0;
            o_wrap <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_stop) begin
                        state <= IDLE;
                        o_cnt <= '0;
                    end else if (i_start) begin
                        lim_q      <= i_limit;
                        mode_q     <= i_mode;
                        o_cnt      <= '0;
                        o_wrap_cnt <= '0;
                        state      <= RUN;
                    end else if (state == IDLE) begin
                        o_cnt <= '0;
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        state <= IDLE;
                        o_cnt <= '0;
                    end else if (i_pause) begin
                        state <= PAUSE;
                    end else if (o_cnt == lim_q) begin
                        if (!mode_q) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            o_cnt  <= '0;
                            o_wrap <= 1'b1;
                            if (o_wrap_cnt != WRAP_MAX)
                                o_wrap_cnt <= o_wrap_cnt + 1'b1;
                        end
                    end else begin
                        // o_cnt stays at or below lim_q, so this increment never overflows
                        o_cnt <= o_cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    if (i_stop) begin
                        state <= IDLE;
                        o_cnt <= '0;
                    end else if (!i_pause) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed scenarios plus random commands,
// compared every cycle against a rule-level reference model.
module tb_counter_seq_ctrl;

    localparam int WIDTH = 7;
    localparam int WRAPW = 8;
    localparam int WMAX  = (1 << WRAPW) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_stop = 1'b0;
    logic             i_pause = 1'b0;
    logic             i_mode = 1'b0;
    logic [WIDTH-1:0] i_limit = '0;
    logic [WIDTH-1:0] o_cnt;
    logic [1:0]       o_state;
    logic             o_busy;
    logic             o_done;
    logic             o_wrap;
    logic [WRAPW-1:0] o_wrap_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state (0 idle, 1 run, 2 pause, 3 done)
    int m_state, m_cnt, m_lim, m_mode, m_wc, m_done, m_wrap;
    int edge_no;

    counter_seq_ctrl #(.WIDTH(WIDTH), .DEFAULT_LIMIT(100), .WRAPW(WRAPW)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_stop(i_stop),
        .i_pause(i_pause), .i_mode(i_mode), .i_limit(i_limit), .o_cnt(o_cnt),
        .o_state(o_state), .o_busy(o_busy), .o_done(o_done), .o_wrap(o_wrap),
        .o_wrap_cnt(o_wrap_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_lim = 100; m_mode = 0; m_wc = 0; m_done = 0; m_wrap = 0;
    endtask

    // Applies the command rules for one edge, using the inputs present before that edge.
    task automatic model_step(input int st, input int sp, input int pa, input int md, input int lm);
        m_done = 0;
        m_wrap = 0;
        if (sp != 0) begin
            m_state = 0;
            m_cnt = 0;
        end else if (m_state == 0 || m_state == 3) begin
            if (st != 0) begin
                m_lim = lm; m_mode = md; m_cnt = 0; m_wc = 0; m_state = 1;
            end
        end else if (m_state == 2) begin
            if (pa == 0) m_state = 1;
        end else if (pa != 0) begin
            m_state = 2;
        end else if (m_cnt < m_lim) begin
            m_cnt = m_cnt + 1;
        end else if (m_mode == 0) begin
            m_state = 3; m_done = 1;
        end else begin
            m_cnt = 0; m_wrap = 1;
            m_wc = (m_wc + 1 > WMAX) ? WMAX : m_wc + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cnt"}, o_cnt, m_cnt);
        chk({tag, ".state"}, o_state, m_state);
        chk({tag, ".busy"}, o_busy, (m_state == 1 || m_state == 2) ? 1 : 0);
        chk({tag, ".done"}, o_done, m_done);
        chk({tag, ".wrap"}, o_wrap, m_wrap);
        chk({tag, ".wrap_cnt"}, o_wrap_cnt, m_wc);
    endtask

    task automatic tick(input string tag);
        int st, sp, pa, md, lm;
        st = i_start; sp = i_stop; pa = i_pause; md = i_mode; lm = int'(i_limit);
        @(posedge clk);
        model_step(st, sp, pa, md, lm);
        edge_no++;
        #1;
        check_all(tag);
    endtask

    task automatic start_cmd(input logic mode, input int lim);
        i_start = 1'b1; i_mode = mode; i_limit = WIDTH'(lim);
        tick("start");
        i_start = 1'b0;
        edge_no = 0;
    endtask

    task automatic stop_cmd();
        i_stop = 1'b1;
        tick("stop");
        i_stop = 1'b0;
    endtask

    initial begin
        int done_edge, wrap1, wrap2, nwrap, nd;
        model_reset();
        edge_no = 0;

        // reset values before any clock edge
        #2;
        check_all("por");
        #10;
        reset_n = 1'b1;
        tick("idle0");
        tick("idle1");

        // asynchronous reset in the middle of a run
        start_cmd(1'b0, 100);
        for (int k = 0; k < 200 && m_cnt != 37; k++) tick("to37");
        chk("reach_cnt37", o_cnt, 37);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst.cnt", o_cnt, 0);
        chk("async_rst.state", o_state, 0);
        chk("async_rst.busy", o_busy, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) tick("post_rst_idle");

        // one-shot, limit 100
        start_cmd(1'b0, 100);
        done_edge = -1; nd = 0;
        for (int k = 0; k < 110; k++) begin
            tick("oneshot");
            if (o_done === 1'b1) begin
                nd++;
                if (done_edge < 0) done_edge = edge_no;
            end
        end
        chk("oneshot.done_edge", done_edge, 101);
        chk("oneshot.done_pulses", nd, 1);
        chk("oneshot.hold", o_cnt, 100);
        chk("oneshot.state", o_state, 3);
        stop_cmd();

        // periodic, limit 99
        start_cmd(1'b1, 99);
        wrap1 = -1; wrap2 = -1;
        for (int k = 0; k < 249; k++) begin
            tick("periodic");
            if (o_wrap === 1'b1) begin
                if (wrap1 < 0) wrap1 = edge_no;
                else if (wrap2 < 0) wrap2 = edge_no;
            end
        end
        chk("periodic.wrap1", wrap1, 100);
        chk("periodic.wrap2", wrap2, 200);
        chk("periodic.wrap_cnt", o_wrap_cnt, 2);
        chk("periodic.cnt_end", o_cnt, 49);
        stop_cmd();

        // pause at 20 for five edges
        start_cmd(1'b0, 100);
        for (int k = 0; k < 200 && m_cnt != 20; k++) tick("to20");
        i_pause = 1'b1;
        for (int k = 0; k < 5; k++) tick("paused");
        chk("pause.cnt", o_cnt, 20);
        chk("pause.busy", o_busy, 1);
        i_pause = 1'b0;
        tick("resume_edge");
        tick("resume_count");
        chk("resume.cnt", o_cnt, 21);
        done_edge = -1;
        for (int k = 0; k < 120 && done_edge < 0; k++) begin
            tick("pause_run");
            if (o_done === 1'b1) done_edge = edge_no;
        end
        chk("pause.done_edge", done_edge, 107);
        stop_cmd();

        // priorities
        i_start = 1'b1; i_stop = 1'b1; i_limit = 7'd9;
        tick("start_stop_idle");
        i_start = 1'b0; i_stop = 1'b0;
        chk("start_stop_idle.state", o_state, 0);
        start_cmd(1'b0, 10);
        for (int k = 0; k < 5; k++) tick("to5");
        i_stop = 1'b1; i_pause = 1'b1;
        tick("stop_pause_run");
        i_stop = 1'b0; i_pause = 1'b0;
        chk("stop_pause.cnt", o_cnt, 0);
        chk("stop_pause.state", o_state, 0);
        start_cmd(1'b0, 10);
        tick("run_a");
        i_start = 1'b1; i_mode = 1'b1; i_limit = 7'd3;
        tick("start_in_run");
        i_start = 1'b0;
        done_edge = -1;
        for (int k = 0; k < 20 && done_edge < 0; k++) begin
            tick("ignored_start");
            if (o_done === 1'b1) done_edge = edge_no;
        end
        chk("start_ignored.done_edge", done_edge, 11);
        chk("start_ignored.cnt", o_cnt, 10);

        // limit 0 one-shot from DONE (restart path)
        start_cmd(1'b0, 0);
        tick("lim0_e1");
        chk("lim0.done_e1", o_done, 1);
        chk("lim0.state", o_state, 3);

        // limit 0 periodic: wrap every cycle
        start_cmd(1'b1, 0);
        for (int k = 0; k < 3; k++) begin
            tick("lim0_periodic");
            chk("lim0_periodic.wrap", o_wrap, 1);
        end
        stop_cmd();

        // limit 127 periodic, tally saturation, then restart clears it
        start_cmd(1'b1, 127);
        nwrap = 0;
        for (int k = 0; k < 300 * 128; k++) begin
            tick("lim127");
            if (o_wrap === 1'b1) nwrap++;
        end
        chk("lim127.wraps", nwrap, 300);
        chk("lim127.sat", o_wrap_cnt, 255);
        stop_cmd();
        chk("stop_keeps_tally", o_wrap_cnt, 255);
        start_cmd(1'b1, 127);
        chk("restart_clears", o_wrap_cnt, 0);

        // random commands against the model
        for (int k = 0; k < 4000; k++) begin
            i_stop  = ($urandom_range(0, 40) == 0);
            i_start = ($urandom_range(0, 12) == 0);
            i_pause = ($urandom_range(0, 7) == 0);
            i_mode  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: i_limit = '0;
                1: i_limit = '1;
                default: i_limit = WIDTH'($urandom_range(0, 40));
            endcase
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
